// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates one single-port RAM between an icache and a dcache.
//  * The grant is registered. A request is sampled in one cycle and the
//    serving state starts in the next cycle.
//  * The dcache has priority. A dcache grant is held while the dcache keeps
//    requesting, so block fills and writebacks are not interleaved.
//  * A starvation counter tracks DSERVE cycles in which the icache waits.
//    When it reaches STARVE_LIMIT, the dcache grant is preempted at the next
//    completed word.
//  * Optional feature macro: MEM_ARB_STATS_EN. When it is defined, icount and
//    dcount count completed words. When it is not defined, both are tied to
//    zero and no counter flops are built.
//
// Handshake: a grant is held in DSERVE or ISERVE. A word completes in any
// serving cycle where ramstate == ACCESS. The served side's wait output is
// low in exactly that cycle and high in every other cycle. The requester
// must hold its request and its address/data stable until it sees wait low.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = DSERVE, 2 = ISERVE.
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   // icache side
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   // dcache side
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   // RAM side
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   // status
   output logic        ramerr,
   output logic [31:0] icount,
   output logic [31:0] dcount,
   // debug view of the arbitration state
   output logic [1:0]  dbg_state
);

   // RAM status encoding
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   // The counter must be wide enough to hold STARVE_LIMIT itself.
   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t LIMIT = cnt_t'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DSERVE = 2'd1,
      ISERVE = 2'd2
   } state_t;

   state_t state_q, state_d;
   cnt_t   starve_q, starve_d;
   logic   ramerr_q, ramerr_d;

   logic   d_req;
   logic   serving;
   logic   word_done;
   logic   starved;

   // Decode the request, the completion and the starvation condition.
   always_comb begin
      d_req     = dREN | dWEN;
      serving   = (state_q == DSERVE) || (state_q == ISERVE);
      word_done = serving && (ramstate == RAM_ACCESS);
      starved   = (starve_q == LIMIT);
   end

   // State register and status flops. Reset is asynchronous, so the IDLE
   // outputs (no strobes, both waits high) appear as soon as nRST falls.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         starve_q <= '0;
         ramerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         ramerr_q <= ramerr_d;
      end
   end

   // Next-state logic and the RAM / cache-side outputs for the current grant.
   always_comb begin
      state_d  = state_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iload    = '0;
      dload    = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (d_req)     state_d = DSERVE;
            else if (iREN) state_d = ISERVE;
            else           state_d = IDLE;
         end
         DSERVE: begin
            ramaddr  = daddr;
            ramstore = dstore;
            // A write wins when both strobes are raised.
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dload    = ramload;
            dwait    = ~word_done;
            // Preemption happens only on a word boundary.
            if (word_done && starved && iREN) state_d = ISERVE;
            else if (d_req)                   state_d = DSERVE;
            else if (iREN)                    state_d = ISERVE;
            else                              state_d = IDLE;
         end
         ISERVE: begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            iload   = ramload;
            iwait   = ~word_done;
            // On completion, or when the fetch is aborted, give the dcache
            // its turn first. A dropped fetch never leads back to ISERVE.
            if (word_done || !iREN) begin
               if (d_req)     state_d = DSERVE;
               else if (iREN) state_d = ISERVE;
               else           state_d = IDLE;
            end else begin
               state_d = ISERVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Starvation counter: counts DSERVE cycles in which the icache waits and
   // saturates at LIMIT. It is zero whenever the grant is not held by DSERVE
   // across the edge, so it clears on entry to ISERVE and while in IDLE.
   always_comb begin
      starve_d = '0;
      if ((state_q == DSERVE) && (state_d == DSERVE)) begin
         if (iREN && !starved) starve_d = starve_q + cnt_t'(1);
         else                  starve_d = starve_q;
      end
   end

   // Sticky error flag. It is set while serving and cleared only by reset.
   always_comb begin
      ramerr_d = ramerr_q | (serving && (ramstate == RAM_ERROR));
   end

   assign ramerr    = ramerr_q;
   assign dbg_state = state_q;

`ifdef MEM_ARB_STATS_EN
   logic [31:0] icount_q, icount_d;
   logic [31:0] dcount_q, dcount_d;

   // Completed-word counters. They wrap naturally at 2^32.
   always_comb begin
      icount_d = icount_q;
      dcount_d = dcount_q;
      if (word_done && (state_q == ISERVE)) icount_d = icount_q + 32'd1;
      if (word_done && (state_q == DSERVE)) dcount_d = dcount_q + 32'd1;
   end

   // Counter registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         icount_q <= '0;
         dcount_q <= '0;
      end else begin
         icount_q <= icount_d;
         dcount_q <= dcount_d;
      end
   end

   assign icount = icount_q;
   assign dcount = dcount_q;
`else
   assign icount = '0;
   assign dcount = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiters (STARVE_LIMIT 8 and 4) share one set of stimulus. A
// cycle-level reference model of the arbitration rules predicts every output
// of each instance. Directed scenarios come first, then a randomized phase
// that includes occasional resets.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  // ---------------- stimulus ----------------
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;

  // ---------------- DUT outputs (index 0: limit 8, index 1: limit 4) ------
  logic [31:0] iload_w [2];
  logic [31:0] dload_w [2];
  logic [31:0] addr_w  [2];
  logic [31:0] store_w [2];
  logic [31:0] icnt_w  [2];
  logic [31:0] dcnt_w  [2];
  logic        iwait_w [2];
  logic        dwait_w [2];
  logic        ren_w   [2];
  logic        wen_w   [2];
  logic        err_w   [2];
  logic [1:0]  st_w    [2];

  mem_arbiter u_dut8 (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload_w[0]), .iwait(iwait_w[0]),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload_w[0]), .dwait(dwait_w[0]),
    .ramREN(ren_w[0]), .ramWEN(wen_w[0]), .ramaddr(addr_w[0]), .ramstore(store_w[0]),
    .ramload(ramload), .ramstate(ramstate),
    .ramerr(err_w[0]), .icount(icnt_w[0]), .dcount(dcnt_w[0]), .dbg_state(st_w[0])
  );

  mem_arbiter #(.STARVE_LIMIT(4)) u_dut4 (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload_w[1]), .iwait(iwait_w[1]),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload_w[1]), .dwait(dwait_w[1]),
    .ramREN(ren_w[1]), .ramWEN(wen_w[1]), .ramaddr(addr_w[1]), .ramstore(store_w[1]),
    .ramload(ramload), .ramstate(ramstate),
    .ramerr(err_w[1]), .icount(icnt_w[1]), .dcount(dcnt_w[1]), .dbg_state(st_w[1])
  );

  // ---------------- scoreboard ----------------
  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = dcache, 2 = icache (this matches dbg_state)
  int          m_owner [2], n_owner [2];
  int          m_wait  [2], n_wait  [2];   // icache wait cycles spent under a dcache grant
  bit          m_err   [2], n_err   [2];
  logic [31:0] m_ic    [2], n_ic    [2];
  logic [31:0] m_dc    [2], n_dc    [2];

  function automatic int limit_of(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0; m_wait[i] = 0; m_err[i] = 0; m_ic[i] = '0; m_dc[i] = '0;
      n_owner[i] = 0; n_wait[i] = 0; n_err[i] = 0; n_ic[i] = '0; n_dc[i] = '0;
    end
  endtask

  // Let the inputs settle, then compare every output of both instances
  // against the model. Also work out the model's next cycle.
  task automatic settle();
    string       p;
    int          o, nx;
    bit          dreq, done, e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    #1;
    if (!nRST) model_reset();
    for (int i = 0; i < 2; i++) begin
      p     = (i == 0) ? "L8" : "L4";
      o     = m_owner[i];
      dreq  = dREN | dWEN;
      done  = (o != 0) && (ramstate == RS_ACCESS);
      e_ren   = (o == 2) || ((o == 1) && dREN && !dWEN);
      e_wen   = (o == 1) && dWEN;
      e_addr  = (o == 1) ? daddr  : ((o == 2) ? iaddr : 32'd0);
      e_store = (o == 1) ? dstore : 32'd0;
      e_il    = (o == 2) ? ramload : 32'd0;
      e_dl    = (o == 1) ? ramload : 32'd0;
      e_iw    = !((o == 2) && done);
      e_dw    = !((o == 1) && done);
      check({p, ".state"},    32'(st_w[i]),    32'(o));
      check({p, ".ramREN"},   32'(ren_w[i]),   32'(e_ren));
      check({p, ".ramWEN"},   32'(wen_w[i]),   32'(e_wen));
      check({p, ".ramaddr"},  addr_w[i],       e_addr);
      check({p, ".ramstore"}, store_w[i],      e_store);
      check({p, ".iload"},    iload_w[i],      e_il);
      check({p, ".dload"},    dload_w[i],      e_dl);
      check({p, ".iwait"},    32'(iwait_w[i]), 32'(e_iw));
      check({p, ".dwait"},    32'(dwait_w[i]), 32'(e_dw));
      check({p, ".ramerr"},   32'(err_w[i]),   32'(m_err[i]));
      check({p, ".icount"},   icnt_w[i],       STATS ? m_ic[i] : 32'd0);
      check({p, ".dcount"},   dcnt_w[i],       STATS ? m_dc[i] : 32'd0);
      // next grant
      if (o == 0)      nx = dreq ? 1 : (iREN ? 2 : 0);
      else if (o == 1) nx = (done && (m_wait[i] == limit_of(i)) && iREN) ? 2 :
                            (dreq ? 1 : (iREN ? 2 : 0));
      else             nx = (done || !iREN) ? (dreq ? 1 : (iREN ? 2 : 0)) : 2;
      if (!nRST) begin
        n_owner[i] = 0; n_wait[i] = 0; n_err[i] = 0; n_ic[i] = '0; n_dc[i] = '0;
      end else begin
        n_owner[i] = nx;
        if ((o == 1) && (nx == 1))
          n_wait[i] = iREN ? ((m_wait[i] + 1 > limit_of(i)) ? limit_of(i) : m_wait[i] + 1) : m_wait[i];
        else
          n_wait[i] = 0;
        n_err[i] = m_err[i] | ((o != 0) && (ramstate == RS_ERROR));
        n_ic[i]  = m_ic[i] + 32'((o == 2) && done);
        n_dc[i]  = m_dc[i] + 32'((o == 1) && done);
      end
    end
  endtask

  // Move across the active edge, commit the model, then wait for the next low phase.
  task automatic advance();
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      if (!nRST) begin
        m_owner[i] = 0; m_wait[i] = 0; m_err[i] = 0; m_ic[i] = '0; m_dc[i] = '0;
      end else begin
        m_owner[i] = n_owner[i]; m_wait[i] = n_wait[i]; m_err[i] = n_err[i];
        m_ic[i] = n_ic[i]; m_dc[i] = n_dc[i];
      end
    end
    @(negedge CLK);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle(input int n);
    iREN = 0; dREN = 0; dWEN = 0; ramstate = RS_FREE;
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- main sequence ----------------
  logic [1:0] st8 [20];
  logic [1:0] st4 [20];
  int         dserve8;

  initial begin
    checks = 0; failures = 0;
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = 32'hA5A5_5A5A; ramstate = RS_FREE;
    model_reset();
    @(negedge CLK);

    // reset state
    settle();
    check("rst.iwait", 32'(iwait_w[0]), 32'd1);
    check("rst.dwait", 32'(dwait_w[0]), 32'd1);
    check("rst.iload", iload_w[0], 32'd0);
    advance();
    tick();
    nRST = 1;
    idle(2);

    // single icache fetch that completes in its second ISERVE cycle
    iREN = 1; iaddr = 32'h40; ramstate = RS_FREE;
    tick();
    ramstate = RS_BUSY;
    settle();
    check("fetch.busy.iwait", 32'(iwait_w[0]), 32'd1);
    advance();
    ramstate = RS_ACCESS; ramload = 32'hDEAD_BEEF;
    settle();
    check("fetch.iload", iload_w[0], 32'hDEAD_BEEF);
    check("fetch.iwait", 32'(iwait_w[0]), 32'd0);
    check("fetch.ramaddr", addr_w[0], 32'h40);
    advance();
    ramstate = RS_BUSY;
    settle();
    check("fetch.iwait_after", 32'(iwait_w[0]), 32'd1);
    check("fetch.icount", icnt_w[0], STATS ? 32'd1 : 32'd0);
    advance();
    idle(2);

    // simultaneous icache read and dcache write: the dcache goes first
    iREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'h1234; ramstate = RS_FREE;
    tick();
    settle();
    check("prio.state", 32'(st_w[0]), 32'd1);
    check("prio.ramWEN", 32'(wen_w[0]), 32'd1);
    check("prio.ramstore", store_w[0], 32'h1234);
    check("prio.ramaddr", addr_w[0], 32'h100);
    advance();
    dWEN = 0;
    tick();
    settle();
    check("prio.then_iserve", 32'(st_w[0]), 32'd2);
    check("prio.iaddr", addr_w[0], 32'h40);
    advance();
    idle(2);

    // dcache held with icache waiting, RAM completes every third cycle
    dREN = 1; iREN = 1; daddr = 32'h200;
    for (int j = 0; j < 20; j++) begin
      ramstate = (j % 3 == 2) ? RS_ACCESS : RS_BUSY;
      ramload  = $urandom;
      settle();
      st8[j] = st_w[0];
      st4[j] = st_w[1];
      advance();
    end
    dserve8 = 0;
    for (int j = 1; j < 12; j++) if (st8[j] == 2'd1) dserve8++;
    check("starve.L8.no_interleave", 32'(dserve8), 32'd11);
    check("starve.L8.preempt", 32'(st8[12]), 32'd2);
    check("starve.L4.before", 32'(st4[5]), 32'd1);
    check("starve.L4.enter", 32'(st4[6]), 32'd2);
    check("starve.L4.hold", 32'(st4[8]), 32'd2);
    check("starve.L4.resume", 32'(st4[9]), 32'd1);
    idle(3);

    // RAM error during a dcache access
    dREN = 1; daddr = 32'h300;
    tick();
    ramstate = RS_ERROR;
    settle();
    check("err.dwait", 32'(dwait_w[0]), 32'd1);
    advance();
    dREN = 0; ramstate = RS_FREE;
    settle();
    check("err.sticky", 32'(err_w[0]), 32'd1);
    advance();
    idle(3);
    settle();
    check("err.still", 32'(err_w[0]), 32'd1);
    advance();

    // reset in the middle of a dcache write
    dWEN = 1; daddr = 32'h400; dstore = 32'h5555_AAAA;
    tick();
    settle();
    check("midrst.wen_before", 32'(wen_w[0]), 32'd1);
    nRST = 0;
    #1;
    check("midrst.wen", 32'(wen_w[0]), 32'd0);
    check("midrst.state", 32'(st_w[0]), 32'd0);
    check("midrst.icount", icnt_w[0], 32'd0);
    check("midrst.dcount", dcnt_w[0], 32'd0);
    check("midrst.ramerr", 32'(err_w[0]), 32'd0);
    model_reset();
    advance();
    tick();
    nRST = 1;
    settle();
    check("midrst.release_wen", 32'(wen_w[0]), 32'd0);
    advance();
    settle();
    check("midrst.wen_again", 32'(wen_w[0]), 32'd1);
    advance();
    idle(2);

    // randomized traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      int r;
      nRST = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 3) == 0) iREN = ~iREN;
      if ($urandom_range(0, 4) == 0) dREN = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) dWEN = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 19);
      if (r < 6)       ramstate = RS_BUSY;
      else if (r < 13) ramstate = RS_ACCESS;
      else if (r < 19) ramstate = RS_FREE;
      else             ramstate = RS_ERROR;
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      tick();
    end
    nRST = 1;
    idle(2);

    // final reset check
    nRST = 0;
    settle();
    check("final.state", 32'(st_w[1]), 32'd0);
    check("final.ramerr", 32'(err_w[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of icache wait cycles after which the dcache grant is preempted at the next word boundary.
REQ-002 SHALL have ports CLK in 1 (clock) and nRST in 1 (reset; asynchronous, active-low).
REQ-003 SHALL have icache-side ports: iREN in 1 (fetch request); iaddr in 32 (fetch address); iload out 32 (fetched word); iwait out 1 (high until the word completes).
REQ-004 SHALL have dcache-side ports: dREN in 1; dWEN in 1; daddr in 32; dstore in 32; dload out 32; dwait out 1.
REQ-005 SHALL have RAM-side ports: ramREN out 1; ramWEN out 1; ramaddr out 32; ramstore out 32; ramload in 32; ramstate in 2 (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-006 SHALL have status ports ramerr out 1 (sticky error flag), icount out 32 and dcount out 32 (completed-word counters).

Function
REQ-007 SHALL use states IDLE, DSERVE and ISERVE; the grant is registered and the state changes one cycle after the request is sampled.
REQ-008 In IDLE: if dREN|dWEN, next state SHALL be DSERVE; else if iREN, ISERVE; else IDLE. The dcache has priority on simultaneous requests.
REQ-009 In IDLE: ramREN=ramWEN=0, iwait=dwait=1.
REQ-010 In DSERVE: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (a write wins when both are asserted); dload=ramload; iwait=1.
REQ-011 In ISERVE: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0, iload=ramload; dwait=1.
REQ-012 A word SHALL complete in any cycle where the state is xSERVE and ramstate==ACCESS; the served wait SHALL be 0 only in that cycle, and 1 otherwise, including for FREE, BUSY and ERROR.
REQ-013 DSERVE SHALL persist while dREN|dWEN is asserted, so that multi-word block writeback or fill sequences are not interleaved.
REQ-014 In DSERVE with dREN=dWEN=0, next state SHALL be ISERVE if iREN, else IDLE.
REQ-015 A starvation counter SHALL increment every DSERVE cycle with iREN=1, saturating at STARVE_LIMIT; it SHALL clear on entry to ISERVE and in IDLE.
REQ-016 In DSERVE, on a word completion with counter==STARVE_LIMIT and iREN=1, next state SHALL be ISERVE regardless of the dcache request.
REQ-017 In ISERVE, on a word completion, next state SHALL be DSERVE if dREN|dWEN, else ISERVE if iREN, else IDLE.
REQ-018 In ISERVE, if iREN drops before completion (abort), next state SHALL be DSERVE if a dcache request is pending, else IDLE, with no RAM strobe in the following cycle.
REQ-019 ramerr SHALL set on any cycle with ramstate==ERROR while serving, and SHALL clear only on reset.
REQ-020 Unserved load outputs (iload/dload) SHALL drive 0.

Reset
REQ-021 On nRST low, asynchronously: state=IDLE, starvation counter=0, ramerr=0, icount=dcount=0.
REQ-022 During reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
REQ-023 A reset asserted mid-transfer SHALL abandon the transfer; no strobe SHALL be driven in the first cycle after release.

Configuration
REQ-024 With macro MEM_ARB_STATS_EN defined, icount/dcount SHALL increment by 1 on each completed icache/dcache word, wrapping from 0xFFFFFFFF to 0.
REQ-025 Without MEM_ARB_STATS_EN, icount and dcount SHALL be tied to 0 and no counter flops SHALL be generated; the ports SHALL remain.

Verification
REQ-026 iREN=1, iaddr=0x40, ramstate ACCESS on the 2nd ISERVE cycle, ramload=0xDEADBEEF -> iload=0xDEADBEEF with iwait=0 for exactly one cycle; icount=1 (stats on).
REQ-027 iREN and dWEN rise together, daddr=0x100, dstore=0x1234 -> DSERVE first, ramWEN=1, ramstore=0x1234; ISERVE follows after dWEN drops.
REQ-028 Two-word dcache fill with iREN held, STARVE_LIMIT=8, ramstate ACCESS every 3rd cycle -> both dcache words are served back-to-back, with no icache interleave before the counter reaches 8.
REQ-029 dREN held for 20 cycles with iREN=1, STARVE_LIMIT=4 -> ISERVE is entered right after the first word completion at or beyond the 4th wait cycle; one icache word is served, then DSERVE resumes.
REQ-030 ramstate=ERROR for one cycle during DSERVE -> dwait stays 1 and ramerr=1 until nRST is asserted.
REQ-031 nRST pulsed low mid-DSERVE with ramWEN=1 -> ramWEN=0 immediately, state=IDLE, counters=0.
